// File: rtl/rom_seq_ctrl_pkg.sv
// Shared types and constants for the ROM-driven instruction sequencer.
// Opcodes occupy the top three bits of every 9-bit instruction word.
package rom_seq_ctrl_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 9;
    localparam int WDOG_W = 4;

    localparam logic [WDOG_W-1:0] WDOG_MAX = 4'd15;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_ISSUE,
        ST_IMM_FETCH,
        ST_IMM_LATCH,
        ST_IMM_ISSUE,
        ST_EXEC,
        ST_HALTED,
        ST_ERROR
    } state_e;

    function automatic logic [2:0] opcode_of(input logic [DATA_W-1:0] w);
        return w[DATA_W-1 -: 3];
    endfunction

endpackage

// File: rtl/rom_seq_ctrl_if.sv
// Bundle of the sequencer's control, ROM and processor-side signals.
// The slave modport is the sequencer; the master modport is its environment.
interface rom_seq_ctrl_if;
    import rom_seq_ctrl_pkg::*;

    logic              start;
    logic              stop;
    logic              done;
    logic [DATA_W-1:0] rom_data;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] din;
    logic              run;
    logic              busy;
    logic              halted;
    logic              err;

    modport master (
        output start, stop, done, rom_data,
        input  rom_addr, din, run, busy, halted, err
    );

    modport slave (
        input  start, stop, done, rom_data,
        output rom_addr, din, run, busy, halted, err
    );

endinterface

// File: rtl/rom_seq_ctrl.sv
// Fetches instructions (and mvi immediates) from a ROM and issues them to a
// processor, with stop/resume, halt decode and an EXEC watchdog.
module rom_seq_ctrl
    import rom_seq_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    rom_seq_ctrl_if.slave io_bus
);

    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_MAX - 4'd1;

    state_e             r_state;
    state_e             w_next;
    logic [ADDR_W-1:0]  r_pc;
    logic [DATA_W-1:0]  r_instr;
    logic [DATA_W-1:0]  r_imm;
    logic [DATA_W-1:0]  r_din_hold;
    logic [WDOG_W-1:0]  r_wdog;
    logic               r_err;
    logic               r_stop_pend;

    logic               w_busy;
    logic               w_restart;
    logic               w_stop_now;
    logic [DATA_W-1:0]  w_din;

    assign w_busy     = (r_state != ST_IDLE) && (r_state != ST_HALTED) &&
                        (r_state != ST_ERROR);
    assign w_restart  = ((r_state == ST_HALTED) || (r_state == ST_ERROR)) &&
                        io_bus.start;
    assign w_stop_now = r_stop_pend || io_bus.stop;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      if (io_bus.start) w_next = ST_FETCH;
            ST_FETCH:     w_next = ST_LATCH;
            ST_LATCH:     w_next = (opcode_of(io_bus.rom_data) == OP_HALT) ?
                                   ST_HALTED : ST_ISSUE;
            ST_ISSUE:     w_next = (opcode_of(r_instr) == OP_MVI) ?
                                   ST_IMM_FETCH : ST_EXEC;
            ST_IMM_FETCH: w_next = ST_IMM_LATCH;
            ST_IMM_LATCH: w_next = ST_IMM_ISSUE;
            ST_IMM_ISSUE: w_next = ST_EXEC;
            ST_EXEC: begin
                // done wins over a watchdog expiry in the same cycle
                if (io_bus.done)
                    w_next = w_stop_now ? ST_IDLE : ST_FETCH;
                else if (r_wdog == WDOG_LAST)
                    w_next = ST_ERROR;
            end
            ST_HALTED,
            ST_ERROR:     if (io_bus.start) w_next = ST_FETCH;
            default:      w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pc        <= '0;
            r_instr     <= '0;
            r_imm       <= '0;
            r_din_hold  <= '0;
            r_wdog      <= '0;
            r_err       <= 1'b0;
            r_stop_pend <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_din_hold <= w_din;

            if (r_state == ST_LATCH) begin
                r_instr <= io_bus.rom_data;
                r_pc    <= r_pc + 5'd1;
            end else if (r_state == ST_IMM_LATCH) begin
                r_imm   <= io_bus.rom_data;
                r_pc    <= r_pc + 5'd1;
            end else if (w_restart) begin
                r_pc    <= '0;
            end

            if ((w_next == ST_EXEC) && (r_state != ST_EXEC))
                r_wdog <= '0;
            else if ((r_state == ST_EXEC) && !io_bus.done && (r_wdog != WDOG_MAX))
                r_wdog <= r_wdog + 4'd1;

            if (w_next == ST_ERROR)
                r_err <= 1'b1;
            else if (w_restart)
                r_err <= 1'b0;

            if ((w_next == ST_IDLE) || w_restart)
                r_stop_pend <= 1'b0;
            else if (w_busy && io_bus.stop)
                r_stop_pend <= 1'b1;
        end
    end

    // The issued word stays on din after the issue cycle until the next issue.
    always_comb begin
        w_din = r_din_hold;
        if (r_state == ST_ISSUE)
            w_din = r_instr;
        else if (r_state == ST_IMM_ISSUE)
            w_din = r_imm;
    end

    assign io_bus.rom_addr = r_pc;
    assign io_bus.din      = w_din;
    assign io_bus.run      = (r_state == ST_ISSUE) || (r_state == ST_IMM_ISSUE);
    assign io_bus.busy     = w_busy;
    assign io_bus.halted   = (r_state == ST_HALTED);
    assign io_bus.err      = r_err;

endmodule
